gups_arbiter: RTL

Round-robin arbiter that lets NUM_REQ GUPS update engines share one memory port. Each engine issues a locked read-modify-write: a read access, then a write access, while holding its request high. The arbiter grants one engine for the whole transaction, steers the memory handshake to it, and counts completed updates. It sits between the GUPS engine array and the memory controller.

---
 rtl/gups_pkg.sv | 17 +
 rtl/gups_arbiter_if.sv | 33 +++
 rtl/gups_rr_pick.sv | 29 ++
 rtl/gups_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gups_pkg.sv
// Shared definitions for the GUPS memory-port arbiter: FSM states,
// the bus width of engine address/data, and the engine-index width helper.
package gups_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DATA_W = 64;

  // Bits needed to hold an engine index; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gups_arbiter_if.sv
// Engine-array and memory-controller handshake bundle for gups_arbiter.
// The slave view is the arbiter; the master view is everything around it
// (engines driving requests, memory answering with ready/rdata).
interface gups_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import gups_pkg::*;

  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ-1:0]        wr_in;
  logic [NUM_REQ*DATA_W-1:0] addr_in;
  logic [NUM_REQ*DATA_W-1:0] wdata_in;
  logic [NUM_REQ-1:0]        ready_out;
  logic [DATA_W-1:0]         rdata_out;

  logic                      mem_req;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_in, wr_in, addr_in, wdata_in, mem_ready, mem_rdata,
    output ready_out, rdata_out, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_in, wr_in, addr_in, wdata_in, mem_ready, mem_rdata,
    input  ready_out, rdata_out, mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/gups_rr_pick.sv
// Circular priority encoder: returns the first set request found when
// walking upward from ptr+1, wrapping at NUM_REQ. The entry at ptr is
// examined last, which is what makes the arbitration round-robin.
module gups_rr_pick import gups_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  // Scan NUM_REQ positions after ptr; the first hit is latched by the valid flag.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    index = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gups_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ GUPS engines.
// A grant covers a whole locked read-modify-write: it lasts while the
// owner holds its request, or until HOLD_MAX cycles have elapsed.
module gups_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 1024
) (
  input  logic          clk,
  input  logic          reset,
  gups_arbiter_if.slave bus,
  output logic [31:0]   update_count,
  output logic          busy,
  output logic          err_timeout,
  output logic          err_stray
);
  import gups_pkg::*;

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int HOLD_W = ($clog2(HOLD_MAX) > 16) ? $clog2(HOLD_MAX) : 16;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  logic               owner_req;
  logic               owner_wr;
  logic [DATA_W-1:0]  owner_addr;
  logic [DATA_W-1:0]  owner_wdata;

  gups_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (bus.req_in),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Select the registered owner's request fields out of the packed engine buses.
  always_comb begin
    owner_req   = 1'b0;
    owner_wr    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_req   = bus.req_in[i];
        owner_wr    = bus.wr_in[i];
        owner_addr  = bus.addr_in[i*DATA_W +: DATA_W];
        owner_wdata = bus.wdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Steer the owner onto the memory port and route ready back only to it; quiet outside BUSY.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ready_out = '0;
    if (state == BUSY) begin
      bus.mem_req          = owner_req;
      bus.mem_wr           = owner_wr;
      bus.mem_addr         = owner_addr;
      bus.mem_wdata        = owner_wdata;
      bus.ready_out[owner] = bus.mem_ready;
    end
  end

  assign bus.rdata_out = bus.mem_rdata;
  assign busy          = (state == BUSY);

  // Grant FSM with owner/pointer, hold timer, update counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= '0;
      ptr          <= IDX_W'(NUM_REQ - 1);
      hold         <= '0;
      update_count <= '0;
      err_timeout  <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A ready with no owner has nobody to go to; flag it and drop it.
          if (bus.mem_ready) begin
            err_stray <= 1'b1;
          end
          if (pick_valid) begin
            owner <= pick_idx;
            ptr   <= pick_idx;
            hold  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready && owner_wr) begin
            update_count <= update_count + 32'd1;
          end
          hold <= hold + HOLD_W'(1);
          // Timeout wins over a simultaneous release so the flag is never lost.
          if (hold == HOLD_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else if (!owner_req) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
